// File: rtl/wb_audio_stream.sv
// -----------------------------------------------------------------------------
// wb_audio_stream
// Wishbone-controlled audio frame FIFO feeding a codec.
//
// Software fills per-channel staging registers; writing the last channel pushes
// the whole staged frame into a FIFO.  The codec side pops frames with a
// valid/ready handshake.  A level interrupt signals FIFO low-water or a sticky
// error (underrun / overflow).
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   wb_adr_i[31:0]      bus address
//   wb_dat_i[31:0]      write data
//   wb_sel_i[3:0]       byte lane enables
//   wb_stb_i, wb_we_i   strobe, write enable
//   wb_dat_o[31:0]      read data, valid with wb_ack_o
//   wb_ack_o            one-cycle acknowledge
//   frame_o             FIFO head frame, channel 0 in the LSBs
//   frame_valid_o       frame_o holds a valid frame
//   frame_ready_i       codec consumes the head frame when high with valid
//   codec_init_done_i   codec configuration complete (status only)
//   irq_o               level interrupt
// -----------------------------------------------------------------------------
module wb_audio_stream #(
    parameter int          NUM_CH     = 2,
    parameter int          SAMPLE_W   = 24,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                wb_adr_i,
    input  logic [31:0]                wb_dat_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    output logic [31:0]                wb_dat_o,
    output logic                       wb_ack_o,
    output logic [NUM_CH*SAMPLE_W-1:0] frame_o,
    output logic                       frame_valid_o,
    input  logic                       frame_ready_i,
    input  logic                       codec_init_done_i,
    output logic                       irq_o
);

    localparam int FRAME_W = NUM_CH * SAMPLE_W;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Merge the enabled byte lanes of a bus word into a sample; lanes beyond
    // SAMPLE_W fall off when the result is truncated.
    function automatic logic [SAMPLE_W-1:0] merge_bytes(
        input logic [SAMPLE_W-1:0] old_val,
        input logic [31:0]         dat,
        input logic [3:0]          sel
    );
        logic [31:0] w;
        w = 32'd0;
        w[SAMPLE_W-1:0] = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                w[8*b +: 8] = dat[8*b +: 8];
            end else begin
                w[8*b +: 8] = w[8*b +: 8];
            end
        end
        return w[SAMPLE_W-1:0];
    endfunction

    // Registers
    logic                ack_q,      ack_d;
    logic [31:0]         dat_q,      dat_d;
    logic                enable_q,   enable_d;
    logic                irq_en_q,   irq_en_d;
    logic [7:0]          thresh_q,   thresh_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic                irq_q,      irq_d;
    logic [CW-1:0]       count_q,    count_d;
    logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;
    logic                valid_q,    valid_d;
    logic [FRAME_W-1:0]  frame_q,    frame_d;
    logic [SAMPLE_W-1:0] stage_q [NUM_CH];
    logic [SAMPLE_W-1:0] stage_d [NUM_CH];
    logic [FRAME_W-1:0]  mem_q   [FIFO_DEPTH];

    // Combinational helpers
    logic [31:0]         off_s;
    logic [31:0]         ch_word_s;
    logic                access_s, wr_s, rd_s;
    logic                sel_status_s, sel_ctrl_s, sel_thresh_s, sel_ch_s;
    logic                flush_s, w1c_und_s, w1c_ovf_s;
    logic [SAMPLE_W-1:0] stage_mrg_s [NUM_CH];
    logic [FRAME_W-1:0]  push_frame_s;
    logic                push_req_s, push_ok_s, pop_s, full_s, empty_s;
    logic                underrun_set_s, overflow_set_s;
    logic [31:0]         cnt_ext_s;
    logic [7:0]          fill_s;
    logic [31:0]         rdata_s;

    // Address decode; an access is accepted only when no ack is outstanding.
    always_comb begin
        off_s        = wb_adr_i - BASE_ADDR;
        ch_word_s    = (off_s - 32'h0000_0010) >> 2;
        access_s     = wb_stb_i && !ack_q;
        wr_s         = access_s && wb_we_i;
        rd_s         = access_s && !wb_we_i;
        sel_status_s = (off_s == 32'h0000_0000);
        sel_ctrl_s   = (off_s == 32'h0000_0004);
        sel_thresh_s = (off_s == 32'h0000_0008);
        sel_ch_s     = (off_s >= 32'h0000_0010) &&
                       (off_s < (32'h0000_0010 + 32'(4 * NUM_CH))) &&
                       (off_s[1:0] == 2'b00);
    end

    // Control register writes, flush strobe and W1C strobes.
    always_comb begin
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        thresh_d  = thresh_q;
        flush_s   = wr_s && sel_ctrl_s && wb_sel_i[0] && wb_dat_i[2];
        w1c_und_s = wr_s && sel_status_s && wb_sel_i[0] && wb_dat_i[3];
        w1c_ovf_s = wr_s && sel_status_s && wb_sel_i[0] && wb_dat_i[4];
        if (wr_s && sel_ctrl_s && wb_sel_i[0]) begin
            enable_d = wb_dat_i[0];
            irq_en_d = wb_dat_i[1];
        end else begin
            enable_d = enable_q;
            irq_en_d = irq_en_q;
        end
        if (wr_s && sel_thresh_s && wb_sel_i[0]) begin
            thresh_d = wb_dat_i[7:0];
        end else begin
            thresh_d = thresh_q;
        end
    end

    // Staging registers; the pushed frame includes the bytes written this cycle.
    always_comb begin
        push_frame_s = {FRAME_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_s && sel_ch_s && (ch_word_s == 32'(k))) begin
                stage_mrg_s[k] = merge_bytes(stage_q[k], wb_dat_i, wb_sel_i);
            end else begin
                stage_mrg_s[k] = stage_q[k];
            end
            push_frame_s[k*SAMPLE_W +: SAMPLE_W] = stage_mrg_s[k];
            if (flush_s) begin
                stage_d[k] = {SAMPLE_W{1'b0}};
            end else begin
                stage_d[k] = stage_mrg_s[k];
            end
        end
        push_req_s = wr_s && sel_ch_s && (ch_word_s == 32'(NUM_CH - 1)) &&
                     (wb_sel_i != 4'b0000);
    end

    // FIFO pointers, occupancy, sticky flags and the registered head frame.
    always_comb begin
        full_s         = (count_q == DEPTH_C);
        empty_s        = (count_q == {CW{1'b0}});
        // A flush discards any pop requested in the same cycle.
        pop_s          = valid_q && frame_ready_i && !flush_s;
        // When full, a push only fits if a pop frees a slot on the same edge.
        push_ok_s      = push_req_s && (!full_s || pop_s);
        overflow_set_s = push_req_s && full_s && !pop_s;
        underrun_set_s = frame_ready_i && enable_q && empty_s;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // A set event wins over a same-cycle W1C.
        underrun_d = (underrun_q && !w1c_und_s) || underrun_set_s;
        overflow_d = (overflow_q && !w1c_ovf_s) || overflow_set_s;
        valid_d    = enable_d && (count_d != {CW{1'b0}});
        // Head frame as it will be after this edge; a push into an empty FIFO
        // lands in the slot that becomes the head, so bypass the memory.
        if (count_d == {CW{1'b0}}) begin
            frame_d = {FRAME_W{1'b0}};
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            frame_d = push_frame_s;
        end else begin
            frame_d = mem_q[rd_ptr_d];
        end
        irq_d = (irq_en_q && enable_q && ({24'd0, thresh_q} >= 32'(count_q))) ||
                (irq_en_q && (underrun_q || overflow_q));
    end

    // Read data mux and acknowledge.
    always_comb begin
        cnt_ext_s = 32'(count_q);
        // Fill field is 8 bits wide; a 256-deep FIFO that is full reads 255.
        fill_s    = (cnt_ext_s > 32'd255) ? 8'hFF : cnt_ext_s[7:0];
        rdata_s   = 32'd0;
        if (sel_status_s) begin
            rdata_s = {8'd0, fill_s, 11'd0, overflow_q, underrun_q, empty_s,
                       codec_init_done_i, full_s};
        end else if (sel_ctrl_s) begin
            rdata_s = {30'd0, irq_en_q, enable_q};
        end else if (sel_thresh_s) begin
            rdata_s = {24'd0, thresh_q};
        end else if (sel_ch_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_word_s == 32'(k)) begin
                    rdata_s[SAMPLE_W-1:0] = stage_q[k];
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end else begin
            rdata_s = 32'd0;
        end
        ack_d = access_s;
        dat_d = rd_s ? rdata_s : 32'd0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q      <= 1'b0;
            dat_q      <= 32'd0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= 8'd0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
            count_q    <= {CW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            valid_q    <= 1'b0;
            frame_q    <= {FRAME_W{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                stage_q[k] <= {SAMPLE_W{1'b0}};
            end
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            valid_q    <= valid_d;
            frame_q    <= frame_d;
            for (int k = 0; k < NUM_CH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Frame storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (!rst && push_ok_s) begin
            mem_q[wr_ptr_q] <= push_frame_s;
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign frame_o       = frame_q;
    assign frame_valid_o = valid_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_wb_audio_stream.sv
module tb_wb_audio_stream;

    localparam logic [31:0] A_STATUS = 32'h9000_0000;
    localparam logic [31:0] A_CTRL   = 32'h9000_0004;
    localparam logic [31:0] A_THRESH = 32'h9000_0008;
    localparam logic [31:0] A_CH0    = 32'h9000_0010;
    localparam logic [31:0] A_CH1    = 32'h9000_0014;
    localparam int OP_IDLE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;
    localparam int NV      = 25;

    typedef struct {
        int          op;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_fr;
        logic        exp_valid;
        logic [47:0] exp_frame;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = 32'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [47:0] frame_o;
    logic        frame_valid_o;
    logic        frame_ready_i = 1'b0;
    logic        codec_init_done_i = 1'b1;
    logic        irq_o;

    int n_pass  = 0;
    int n_total = 0;
    vec_t vecs [NV];
    logic [47:0] exp_q [$];
    logic [31:0] rd;

    wb_audio_stream dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i), .codec_init_done_i(codec_init_done_i),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // One bus transfer: stb for one cycle, ack expected right after, then idle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic rdy, output logic [31:0] rdata);
        @(negedge clk);
        wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        frame_ready_i = rdy;
        @(posedge clk); #1;
        chk("ack_rise", {63'd0, wb_ack_o}, 64'd1);
        rdata = wb_dat_o;
        @(negedge clk);
        wb_stb_i = 1'b0; wb_we_i = 1'b0; frame_ready_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_single", {63'd0, wb_ack_o}, 64'd0);
    endtask

    task automatic idle(input logic rdy);
        @(negedge clk);
        frame_ready_i = rdy;
        @(posedge clk); #1;
        chk("ack_idle", {63'd0, wb_ack_o}, 64'd0);
        @(negedge clk);
        frame_ready_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [23:0] d);
        logic [31:0] r;
        xfer(1'b1, A_CH1, {8'd0, d}, 4'hF, 1'b0, r);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, adr, 32'd0, 4'hF, 1'b0, r);
        chk(name, {32'd0, r}, {32'd0, exp});
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        xfer(1'b1, adr, dat, 4'hF, 1'b0, r);
    endtask

    // Pop n frames, checking each head against the expected queue before it goes.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("drain_valid%0d", i), {63'd0, frame_valid_o}, 64'd1);
            chk($sformatf("drain_frame%0d", i), {16'd0, frame_o}, {16'd0, exp_q.pop_front()});
            frame_ready_i = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        frame_ready_i = 1'b0;
        chk("drain_empty", {63'd0, frame_valid_o}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_WR,   A_CH0,    32'h0012_3456, 4'hF, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 48'h0};
        vecs[1]  = '{OP_WR,   A_CH1,    32'h00AB_CDEF, 4'hF, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 48'h0};
        vecs[2]  = '{OP_WR,   A_CTRL,   32'h0000_0001, 4'hF, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 48'hABCDEF_123456};
        vecs[3]  = '{OP_RD,   A_STATUS, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0001_0002, 1'b1, 1'b1, 48'hABCDEF_123456};
        vecs[4]  = '{OP_RD,   A_CH0,    32'h0,         4'hF, 1'b0, 1'b1, 32'h0012_3456, 1'b0, 1'b0, 48'h0};
        vecs[5]  = '{OP_RD,   A_CH1,    32'h0,         4'hF, 1'b0, 1'b1, 32'h00AB_CDEF, 1'b0, 1'b0, 48'h0};
        vecs[6]  = '{OP_WR,   A_CH0,    32'h00FF_0000, 4'h4, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 48'hABCDEF_123456};
        vecs[7]  = '{OP_RD,   A_CH0,    32'h0,         4'hF, 1'b0, 1'b1, 32'h00FF_3456, 1'b0, 1'b0, 48'h0};
        vecs[8]  = '{OP_WR,   A_CH1,    32'h0000_0077, 4'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 48'hABCDEF_123456};
        vecs[9]  = '{OP_RD,   A_STATUS, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0002_0002, 1'b0, 1'b0, 48'h0};
        vecs[10] = '{OP_IDLE, 32'h0,    32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 48'hABCD77_FF3456};
        vecs[11] = '{OP_IDLE, 32'h0,    32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 48'h0};
        vecs[12] = '{OP_IDLE, 32'h0,    32'h0,         4'h0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 48'h0};
        vecs[13] = '{OP_RD,   A_STATUS, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0000_000E, 1'b0, 1'b0, 48'h0};
        vecs[14] = '{OP_WR,   A_STATUS, 32'h0000_0008, 4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 48'h0};
        vecs[15] = '{OP_RD,   A_STATUS, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 48'h0};
        vecs[16] = '{OP_RD,   32'h9000_000C, 32'h0,    4'hF, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 48'h0};
        vecs[17] = '{OP_WR,   32'h9000_0018, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 48'h0};
        vecs[18] = '{OP_RD,   32'h9000_0018, 32'h0,    4'hF, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 48'h0};
        vecs[19] = '{OP_WR,   A_THRESH, 32'h0000_01FF, 4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 48'h0};
        vecs[20] = '{OP_RD,   A_THRESH, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 48'h0};
        vecs[21] = '{OP_WR,   A_THRESH, 32'h0,         4'hF, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 48'h0};
        vecs[22] = '{OP_RD,   A_CTRL,   32'h0,         4'hF, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 48'h0};
        vecs[23] = '{OP_RD,   32'h8FFF_FFFC, 32'h0,    4'hF, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 48'h0};
        vecs[24] = '{OP_RD,   A_CH1,    32'h0,         4'hF, 1'b0, 1'b1, 32'h00AB_CD77, 1'b0, 1'b0, 48'h0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ack",   {63'd0, wb_ack_o}, 64'd0);
        chk("rst_dat",   {32'd0, wb_dat_o}, 64'd0);
        chk("rst_valid", {63'd0, frame_valid_o}, 64'd0);
        chk("rst_frame", {16'd0, frame_o}, 64'd0);
        chk("rst_irq",   {63'd0, irq_o}, 64'd0);
        rd_chk("rst_status", A_STATUS, 32'h0000_0006);
        rd_chk("rst_ctrl",   A_CTRL,   32'h0000_0000);

        // Table-driven register / FIFO vectors
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].op == OP_IDLE) idle(vecs[i].rdy);
            else xfer(vecs[i].op == OP_WR, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].rdy, rd);
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rd});
            if (vecs[i].chk_fr) begin
                chk($sformatf("vec%0d_valid", i), {63'd0, frame_valid_o}, {63'd0, vecs[i].exp_valid});
                if (vecs[i].exp_valid)
                    chk($sformatf("vec%0d_frame", i), {16'd0, frame_o}, {16'd0, vecs[i].exp_frame});
            end
        end

        // Overflow: 17 pushes into a 16-deep FIFO with no pops
        for (int i = 0; i < 17; i++) begin
            push(24'(32'h100 + i));
            if (i < 16) exp_q.push_back({24'(32'h100 + i), 24'hFF3456});
        end
        rd_chk("ovf_status", A_STATUS, 32'h0010_0013);
        drain(16);
        wr(A_STATUS, 32'h0000_0010);
        rd_chk("ovf_cleared", A_STATUS, 32'h0000_0006);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            push(24'(32'h200 + i));
            exp_q.push_back({24'(32'h200 + i), 24'hFF3456});
        end
        xfer(1'b1, A_CH1, 32'h0000_02FF, 4'hF, 1'b1, rd);
        void'(exp_q.pop_front());
        exp_q.push_back({24'h0002FF, 24'hFF3456});
        rd_chk("full_pushpop_status", A_STATUS, 32'h0010_0003);
        drain(16);

        // Low-water interrupt
        wr(A_THRESH, 32'h0000_0002);
        wr(A_CTRL, 32'h0000_0003);
        chk("irq_empty", {63'd0, irq_o}, 64'd1);
        push(24'h000300); push(24'h000301); push(24'h000302);
        chk("irq_fill3", {63'd0, irq_o}, 64'd0);
        @(negedge clk); frame_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("irq_pop_edge", {63'd0, irq_o}, 64'd0);
        @(negedge clk); frame_ready_i = 1'b0;
        @(posedge clk); #1;
        chk("irq_rise", {63'd0, irq_o}, 64'd1);
        @(negedge clk);
        wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = A_CH1; wb_dat_i = 32'h0000_0303; wb_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("irq_push_ack", {63'd0, wb_ack_o}, 64'd1);
        chk("irq_push_edge", {63'd0, irq_o}, 64'd1);
        @(negedge clk); wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        chk("irq_fall", {63'd0, irq_o}, 64'd0);

        // Flush at fill 5, with a same-cycle pop request
        wr(A_CTRL, 32'h0000_0001);
        push(24'h000304); push(24'h000305);
        rd_chk("flush_pre_status", A_STATUS, 32'h0005_0002);
        xfer(1'b1, A_CTRL, 32'h0000_0005, 4'hF, 1'b1, rd);
        chk("flush_valid", {63'd0, frame_valid_o}, 64'd0);
        rd_chk("flush_status", A_STATUS, 32'h0000_0006);
        rd_chk("flush_ctrl",   A_CTRL,   32'h0000_0001);
        rd_chk("flush_ch0",    A_CH0,    32'h0000_0000);
        rd_chk("flush_ch1",    A_CH1,    32'h0000_0000);

        // Reset with strobe high: no ack, FIFO discarded
        push(24'h000400);
        chk("pre_rst_valid", {63'd0, frame_valid_o}, 64'd1);
        @(negedge clk);
        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_STATUS; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack",   {63'd0, wb_ack_o}, 64'd0);
        chk("midrst_dat",   {32'd0, wb_dat_o}, 64'd0);
        chk("midrst_valid", {63'd0, frame_valid_o}, 64'd0);
        chk("midrst_frame", {16'd0, frame_o}, 64'd0);
        @(negedge clk); wb_stb_i = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_ack", {63'd0, wb_ack_o}, 64'd0);
        rd_chk("postrst_status", A_STATUS, 32'h0000_0006);
        rd_chk("postrst_ctrl",   A_CTRL,   32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_audio_stream.md
WB_AUDIO_STREAM -- requirements
Module: wb_audio_stream

Interface
REQ-001 Parameter NUM_CH, default 2, number of audio channels per frame (1..8).
REQ-002 Parameter SAMPLE_W, default 24, sample width in bits (8..32).
REQ-003 Parameter FIFO_DEPTH, default 16, frame FIFO depth in frames (power of 2, 2..256).
REQ-004 Parameter BASE_ADDR, default 32'h9000_0000, register block base address.
REQ-005 Reset rst, synchronous, active-high; clock clk.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wb_adr_i  in  32  bus address.
REQ-009 wb_dat_i  in  32  write data.
REQ-010 wb_sel_i  in  4  byte lane enables.
REQ-011 wb_stb_i  in  1  bus strobe.
REQ-012 wb_we_i  in  1  write enable.
REQ-013 wb_dat_o  out  32  read data, valid with wb_ack_o.
REQ-014 wb_ack_o  out  1  one-cycle acknowledge.
REQ-015 frame_o  out  NUM_CH*SAMPLE_W  FIFO head frame, channel 0 in LSBs.
REQ-016 frame_valid_o  out  1  frame_o holds a valid frame.
REQ-017 frame_ready_i  in  1  codec consumes frame when high with frame_valid_o.
REQ-018 codec_init_done_i  in  1  codec configuration complete.
REQ-019 irq_o  out  1  level interrupt, FIFO low-water.

Function
REQ-020 Register map (offset from BASE_ADDR), all other addresses read 0 and ignore writes:
- 0x00 STATUS (RO except W1C): bit0 full, bit1 codec_init_done_i, bit2 empty, bit3 underrun (sticky, W1C), bit4 overflow (sticky, W1C), [23:16] fill level.
- 0x04 CTRL (RW): bit0 enable, bit1 irq_en; write with bit2=1 flushes FIFO and staging (bit2 reads 0).
- 0x08 THRESH (RW): [7:0] low-water level.
- 0x10+4*k, k<NUM_CH: channel k staging sample (RW), SAMPLE_W LSBs, byte-lane masked by wb_sel_i; unused high bits read 0.
REQ-021 wb_ack_o SHALL assert exactly one cycle after each cycle with wb_stb_i=1 and wb_ack_o=0; never two consecutive cycles; no stall.
REQ-022 Register writes and wb_dat_o SHALL take effect on the same clock edge that raises wb_ack_o.
REQ-023 A write to channel NUM_CH-1 with any wb_sel_i bit set SHALL push the staging frame (with the new bytes merged) into the FIFO on the same edge.
REQ-024 Push while count==FIFO_DEPTH and no same-cycle pop SHALL drop the frame and set overflow; FIFO unchanged.
REQ-025 Pop occurs when frame_valid_o && frame_ready_i; frame_valid_o = enable && count!=0.
REQ-026 Simultaneous push and pop SHALL both succeed, including when full; count unchanged.
REQ-027 frame_ready_i=1 while enable=1 and count==0 SHALL set underrun.
REQ-028 frame_o SHALL be the oldest frame, stable while frame_valid_o=1 and not popped.
REQ-029 Fill level SHALL be an exact count 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
REQ-030 irq_o = irq_en && enable && (count <= THRESH) || irq_en && (underrun || overflow), registered (one-cycle latency).
REQ-031 Flush SHALL zero count and pointers and clear staging; a same-cycle pop is discarded; sticky flags retained.
REQ-032 W1C of a sticky flag in the same cycle as a new set event SHALL leave the flag set.

Reset
REQ-033 On rst: wb_ack_o=0, wb_dat_o=0, FIFO empty, frame_valid_o=0, frame_o=0, staging=0, CTRL=0, THRESH=0, sticky flags=0, irq_o=0.
REQ-034 rst mid-transaction SHALL suppress the pending ack and discard the FIFO contents.

Verification
REQ-035 Write ch0=0x123456, ch1=0xABCDEF (defaults), enable=1, frame_ready_i=0 -> frame_valid_o=1, frame_o=0xABCDEF_123456, STATUS fill=1.
REQ-036 17 frame pushes, frame_ready_i=0 -> STATUS full=1, overflow=1, fill=16; first 16 frames drain in order.
REQ-037 Full FIFO, push with frame_ready_i=1 same cycle -> fill stays 16, no overflow, new frame last out.
REQ-038 enable=1, empty, frame_ready_i=1 -> underrun=1; W1C 0x08 to STATUS -> underrun=0.
REQ-039 THRESH=2, irq_en=1, fill drains 3->2 -> irq_o rises next cycle; push to 3 -> irq_o falls.
REQ-040 Fill=5, CTRL write bit2=1 -> next cycle fill=0, frame_valid_o=0; rst asserted with stb high -> no ack.
